// File: rtl/cmd_pkt_tx.sv
// Command-packet transmitter: sends cmd, data[15:8] and data[7:0] as three
// back-to-back 8N1 frames on TX, LSB first, with BAUD_DIV clocks per bit.
module cmd_pkt_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        TX,
  output logic        busy,
  output logic        cmd_sent
);

  // state | meaning
  // IDLE  | line high, waiting for snd_cmd
  // XMIT  | shifting out the three frames of a packet
  typedef enum logic {IDLE, XMIT} state_t;

  localparam logic [11:0] BAUD_TC = 12'(BAUD_DIV - 1);

  state_t      state_q, state_d;
  logic [11:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [9:0]  shift_q, shift_d;
  logic [23:0] hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        cmd_sent_q, cmd_sent_d;

  logic [1:0]  byte_idx_nxt;
  logic [7:0]  next_byte;
  logic        baud_tc;

  assign baud_tc      = (baud_cnt_q == BAUD_TC);
  assign byte_idx_nxt = byte_idx_q + 2'd1;

  always_comb begin
    next_byte = hold_q[23:16];
    case (byte_idx_nxt)
      2'd1:    next_byte = hold_q[15:8];
      2'd2:    next_byte = hold_q[7:0];
      default: next_byte = hold_q[23:16];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    cmd_sent_d = cmd_sent_q;

    case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          hold_d     = {cmd, data};
          shift_d    = {1'b1, cmd, 1'b0};
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          byte_idx_d = '0;
          busy_d     = 1'b1;
          cmd_sent_d = 1'b0;
          state_d    = XMIT;
        end
      end
      XMIT: begin
        if (!baud_tc) begin
          baud_cnt_d = baud_cnt_q + 12'd1;
        end else begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 4'd9) begin
            bit_cnt_d = '0;
            if (byte_idx_q != 2'd2) begin
              // next start bit follows the stop bit with no idle gap
              byte_idx_d = byte_idx_nxt;
              shift_d    = {1'b1, next_byte, 1'b0};
            end else begin
              byte_idx_d = '0;
              shift_d    = '1;
              busy_d     = 1'b0;
              cmd_sent_d = 1'b1;
              state_d    = IDLE;
            end
          end else begin
            shift_d   = {1'b1, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '1;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      cmd_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      cmd_sent_q <= cmd_sent_d;
    end
  end

  // shift_q is all ones whenever idle, so its LSB is the registered line
  assign TX       = shift_q[0];
  assign busy     = busy_q;
  assign cmd_sent = cmd_sent_q;

endmodule

// File: tb/tb_cmd_pkt_tx.sv
// Directed bench for cmd_pkt_tx at BAUD_DIV=8: per-cycle TX compare against
// the expected 30-bit line pattern plus a mid-bit loopback byte decode.
module tb_cmd_pkt_tx;

  localparam int BD = 8;
  localparam int PKT = 30 * BD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [7:0]  cmd = '0;
  logic [15:0] data = '0;
  logic        TX, busy, cmd_sent;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cmd_pkt_tx #(.BAUD_DIV(BD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .snd_cmd  (snd_cmd),
    .cmd      (cmd),
    .data     (data),
    .TX       (TX),
    .busy     (busy),
    .cmd_sent (cmd_sent)
  );

  typedef struct {
    logic [7:0]  c;
    logic [15:0] d;
    int          mode;  // 0 plain, 1 stray request, 2 churn inputs, 3 chain next
    int          gap;
    logic [7:0]  e0, e1, e2;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the end-of-packet edge (edge 240).
  task automatic do_packet(input logic [7:0] c, input logic [15:0] d, input int mode,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [29:0] exp_bits;
    logic [29:0] rx;
    int tx_err;
    int busy_cnt;
    int sent_hi;
    exp_bits = {1'b1, e2, 1'b0, 1'b1, e1, 1'b0, 1'b1, e0, 1'b0};
    rx = '1;
    tx_err = 0;
    busy_cnt = 0;
    sent_hi = 0;
    cmd = c;
    data = d;
    snd_cmd = 1'b1;
    tick;
    snd_cmd = 1'b0;
    check("start_tx", 32'(TX), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_sent", 32'(cmd_sent), 32'd0);
    for (int k = 0; k < PKT; k++) begin
      if (TX !== exp_bits[k / BD]) tx_err++;
      if (k % BD == BD / 2) rx[k / BD] = TX;
      if (busy === 1'b1) busy_cnt++;
      if (cmd_sent !== 1'b0) sent_hi++;
      case (mode)
        1: begin
          if (k == 100) begin
            snd_cmd = 1'b1;
            cmd = 8'h11;
            data = 16'h1234;
          end
          if (k == 101) snd_cmd = 1'b0;
        end
        2: begin
          cmd = 8'($urandom);
          data = 16'($urandom);
        end
        3: begin
          if (k == PKT - 1) begin
            snd_cmd = 1'b1;
            cmd = 8'h04;
            data = 16'h0506;
          end
        end
        default: ;
      endcase
      tick;
    end
    check("tx_bit_errors", 32'(tx_err), 32'd0);
    check("rx_byte0", 32'(rx[8:1]), 32'(e0));
    check("rx_byte1", 32'(rx[18:11]), 32'(e1));
    check("rx_byte2", 32'(rx[28:21]), 32'(e2));
    check("busy_cycles", 32'(busy_cnt), 32'(PKT));
    check("sent_during_busy", 32'(sent_hi), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_sent", 32'(cmd_sent), 32'd1);
    check("end_tx", 32'(TX), 32'd1);
  endtask

  initial begin
    int idle_bad;

    vecs[0] = '{8'h6A, 16'hBEEF, 0, 3, 8'h6A, 8'hBE, 8'hEF};
    vecs[1] = '{8'hA5, 16'h0F0F, 1, 3, 8'hA5, 8'h0F, 8'h0F};
    vecs[2] = '{8'h3C, 16'hC33C, 2, 3, 8'h3C, 8'hC3, 8'h3C};
    vecs[3] = '{8'h01, 16'h0203, 3, 3, 8'h01, 8'h02, 8'h03};
    vecs[4] = '{8'h04, 16'h0506, 0, 0, 8'h04, 8'h05, 8'h06};

    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sent", 32'(cmd_sent), 32'd0);
    idle_bad = 0;
    for (int k = 0; k < 500; k++) begin
      tick;
      if (TX !== 1'b1 || busy !== 1'b0 || cmd_sent !== 1'b0) idle_bad++;
    end
    check("idle_quiet", 32'(idle_bad), 32'd0);

    for (int i = 0; i < 5; i++) begin
      repeat (vecs[i].gap) tick;
      if (i > 0 && vecs[i].gap > 0) check("sent_hold", 32'(cmd_sent), 32'd1);
      do_packet(vecs[i].c, vecs[i].d, vecs[i].mode, vecs[i].e0, vecs[i].e1, vecs[i].e2);
    end
    snd_cmd = 1'b0;

    // Abort a packet with reset at cycle 90 (TX would be low then).
    repeat (3) tick;
    cmd = 8'h5A;
    data = 16'h1234;
    snd_cmd = 1'b1;
    tick;
    snd_cmd = 1'b0;
    repeat (89) tick;
    check("pre_rst_tx", 32'(TX), 32'd0);
    rst_n = 1'b0;
    tick;
    check("midrst_tx", 32'(TX), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sent", 32'(cmd_sent), 32'd0);
    rst_n = 1'b1;
    tick;
    tick;
    check("post_rst_idle_tx", 32'(TX), 32'd1);
    do_packet(8'hFF, 16'h0000, 0, 8'hFF, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
